// File: rtl/fmap_pkg.sv
// Shared types and sizing helpers for the feature-map collector.
package fmap_pkg;

    typedef enum logic {FILL, HOLD} collect_state_t;

    function automatic int flat_elems(int ch, int h, int w);
        return ch * h * w;
    endfunction

    // Index register width; a single-element frame still needs one bit.
    function automatic int idx_width(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fmap_collect.sv
// Streaming-to-flat collector: packs CH*IN_H*IN_W channel-major elements into one
// flat vector and holds it under a valid/ready handshake until it is taken.
module fmap_collect
    import fmap_pkg::*;
#(
    parameter int CH        = 1,
    parameter int IN_H      = 1,
    parameter int IN_W      = 1,
    parameter int WIDTH     = 16,
    parameter     precision = "Q8.8"
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic signed [WIDTH-1:0]         in_data,
    input  logic                            in_last,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic signed [flat_elems(CH, IN_H, IN_W)*WIDTH-1:0] out_vec,
    output logic                            frame_err
);

    localparam int N  = flat_elems(CH, IN_H, IN_W);
    localparam int IW = idx_width(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    // Handshake: an element moves when in_valid && in_ready; a frame moves when
    // out_valid && out_ready. Both readies/valids decode from state alone.
    collect_state_t  state;
    logic [IW-1:0]   idx;
    logic            accept;
    logic            at_end;
    logic [N-1:0]    wr_en;

    assign in_ready  = (state == FILL);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid && (state == FILL);
    assign at_end    = (idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            idx       <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                FILL: begin
                    if (accept) begin
                        if (at_end) begin
                            idx       <= '0;
                            state     <= HOLD;
                            frame_err <= !in_last;
                        end else if (in_last) begin
                            // Early last: drop the element and resync on the next one.
                            idx       <= '0;
                            frame_err <= 1'b1;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) state <= FILL;
                end
                default: state <= FILL;
            endcase
        end
    end

    // One-hot slice write enables; stale words of a dropped frame are kept.
    for (genvar k = 0; k < N; k++) begin : g_slice
        assign wr_en[k] = accept && (idx == IW'(k)) && (at_end || !in_last);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                out_vec[k*WIDTH +: WIDTH] <= '0;
            else if (wr_en[k])
                out_vec[k*WIDTH +: WIDTH] <= in_data;
        end
    end

endmodule

// File: tb/tb_fmap_collect.sv
// Randomized bench for fmap_collect at CH=2, IN_H=2, IN_W=2, WIDTH=16 (N=8).
module tb_fmap_collect;

    localparam int N = 8;
    localparam int W = 16;
    localparam int VW = N * W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [VW-1:0] out_vec;
    logic          frame_err;

    fmap_collect #(.CH(2), .IN_H(2), .IN_W(2), .WIDTH(W), .precision("Q8.8")) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Reference state: whether a frame is being held, how many elements of the
    // current frame have arrived, the expected vector and the expected error pulse.
    bit            m_hold;
    int            m_cnt;
    logic [VW-1:0] m_vec;
    bit            m_err;
    logic [VW-1:0] exp_q[$];
    logic [W-1:0]  fr[N];
    bit            rand_ready;

    int n_cmp = 0;
    int n_mis = 0;
    int err_pulses = 0;
    int taken = 0;

    task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: reference update from the driven inputs, then output checks.
    task automatic cycle();
        logic [VW-1:0] got;
        if (rand_ready) out_ready = ($urandom_range(1, 0) == 1);
        m_err = 0;
        if (m_hold) begin
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 1, 0);
                end else begin
                    got = out_vec;
                    check("frame_data", got, exp_q.pop_front());
                    taken++;
                end
                m_hold = 0;
            end
        end else if (in_valid) begin
            if (in_last && m_cnt < N - 1) begin
                m_err = 1;
                m_cnt = 0;
            end else begin
                m_vec[m_cnt*W +: W] = in_data;
                if (m_cnt == N - 1) begin
                    m_hold = 1;
                    m_err  = !in_last;
                    m_cnt  = 0;
                end else begin
                    m_cnt++;
                end
            end
        end
        @(posedge clk);
        #1;
        if (frame_err) err_pulses++;
        check("in_ready", VW'(in_ready), VW'(!m_hold));
        check("out_valid", VW'(out_valid), VW'(m_hold));
        check("frame_err", VW'(frame_err), VW'(m_err));
        check("out_vec", out_vec, m_vec);
    endtask

    task automatic send(input logic [W-1:0] d, input bit last, input bit gaps);
        int tries = 0;
        bit acc = 0;
        if (gaps) begin
            while ($urandom_range(1, 0) == 1) begin
                in_valid = 0;
                in_data  = W'($urandom);
                cycle();
            end
        end
        in_valid = 1;
        in_data  = d;
        in_last  = last;
        while (!acc && tries < 100) begin
            acc = !m_hold;
            cycle();
            tries++;
        end
        if (!acc) check("send_timeout", 0, 1);
        in_valid = 0;
        in_last  = 0;
        in_data  = W'($urandom);
    endtask

    // last_at = N-1 for a proper frame, -1 for a frame with no last marker.
    task automatic send_frame(input int last_at, input bit gaps);
        logic [VW-1:0] e;
        for (int i = 0; i < N; i++) e[i*W +: W] = fr[i];
        exp_q.push_back(e);
        for (int i = 0; i < N; i++) send(fr[i], i == last_at, gaps);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        rst_n = 0; in_valid = 0; in_data = '0; in_last = 0; out_ready = 0; rand_ready = 0;
        m_hold = 0; m_cnt = 0; m_vec = '0; m_err = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", VW'(in_ready), VW'(1));
        check("rst_out_valid", VW'(out_valid), VW'(0));
        check("rst_frame_err", VW'(frame_err), VW'(0));
        check("rst_out_vec", out_vec, '0);
        rst_n = 1;

        // Basic frame 1..8, consumer always ready.
        out_ready = 1;
        for (int i = 0; i < N; i++) fr[i] = W'(i + 1);
        send_frame(N - 1, 0);
        check("basic_lo", VW'(out_vec[15:0]), VW'(16'h0001));
        check("basic_hi", VW'(out_vec[127:112]), VW'(16'h0008));
        idle(2);

        // Backpressure: junk offered while the frame is held.
        out_ready = 0;
        for (int i = 0; i < N; i++) fr[i] = W'($urandom);
        send_frame(N - 1, 0);
        in_valid = 1; in_last = 1;
        for (int i = 0; i < 5; i++) begin
            in_data = W'($urandom);
            cycle();
        end
        in_valid = 0; in_last = 0;
        out_ready = 1;
        idle(2);

        // Input gaps with negative values, expecting no error.
        err_pulses = 0;
        for (int i = 0; i < N; i++) fr[i] = W'(16'hFFF8 + i);
        send_frame(N - 1, 1);
        idle(2);
        check("gaps_no_err", VW'(err_pulses), VW'(0));

        // Early last on element 3, then a clean frame.
        err_pulses = 0;
        for (int i = 0; i < 4; i++) send(W'(16'hA000 + i), i == 3, 0);
        for (int i = 0; i < N; i++) fr[i] = W'(16'h0100 + i);
        send_frame(N - 1, 0);
        idle(2);
        check("early_err_once", VW'(err_pulses), VW'(1));

        // Missing last: frame completes with one error pulse.
        err_pulses = 0;
        for (int i = 0; i < N; i++) fr[i] = W'(16'h0200 + i);
        send_frame(-1, 0);
        idle(2);
        check("missing_err_once", VW'(err_pulses), VW'(1));

        // Reset after four accepts.
        for (int i = 0; i < 4; i++) send(W'(16'hB000 + i), 0, 0);
        #2 rst_n = 0;
        #1;
        check("midrst_out_vec", out_vec, '0);
        check("midrst_out_valid", VW'(out_valid), VW'(0));
        check("midrst_in_ready", VW'(in_ready), VW'(1));
        m_hold = 0; m_cnt = 0; m_vec = '0; m_err = 0;
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) fr[i] = W'(16'h0300 + i);
        send_frame(N - 1, 0);
        idle(2);

        // Random frames with gaps and random consumer stalls.
        rand_ready = 1;
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < N; i++) fr[i] = W'($urandom);
            send_frame(N - 1, 1);
        end
        for (int t = 0; t < 200 && exp_q.size() != 0; t++) cycle();
        rand_ready = 0;
        check("drain_empty", VW'(exp_q.size()), VW'(0));
        check("frames_taken", VW'(taken), VW'(12));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/fmap_collect.md
# fmap_collect

Streaming-to-flat feature-map collector for the flattened-vector layer modules. It accepts one WIDTH-bit element per handshake in channel-major order, packs CH×IN_H×IN_W elements into a flat vector, and presents the completed frame with a valid/ready handshake. Its `out_vec` drives the `a_vec`/`b_vec` inputs of concat2d directly; one instance sits in front of each concat operand.

## Interface
- `CH`, default 1: channels per frame.
- `IN_H`, default 1: frame height.
- `IN_W`, default 1: frame width.
- `WIDTH`, default 16: element width in bits, signed.
- `precision`, default "Q8.8": fixed-point format tag. Informational only; no arithmetic depends on it.
- Derived `N = CH*IN_H*IN_W`: elements per frame, N ≥ 1.

Ports:
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  `in_data` and `in_last` are valid.
- `in_ready`  out  1  collector can accept an element.
- `in_data`  in  WIDTH, signed  element value.
- `in_last`  in  1  marks the final element of a frame.
- `out_valid`  out  1  `out_vec` holds a complete frame.
- `out_ready`  in  1  consumer takes the frame.
- `out_vec`  out  N*WIDTH, signed  packed frame.
- `frame_err`  out  1  one-cycle pulse on a framing error.

## Operation
- An input is accepted on a cycle where `in_valid && in_ready`. An output is taken on a cycle where `out_valid && out_ready`.
- Packing: element k goes to `out_vec[k*WIDTH +: WIDTH]`, with k = (c*IN_H + y)*IN_W + x. Element 0 occupies the LSBs, which matches concat2d packing.
- Index counter `idx`, 0..N-1: holds the write position of the next accepted element.
- State machine with two states:
  - FILL: `in_ready`=1, `out_valid`=0.
    - Accept with idx < N-1 and `in_last`=0: write the element, then idx++.
    - Accept with idx < N-1 and `in_last`=1 (early last): pulse `frame_err`, discard the element, set idx=0, stay in FILL. This resynchronises on the next element.
    - Accept with idx == N-1: write the element, set idx=0, go to HOLD. If `in_last`=0, also pulse `frame_err`; the frame still completes.
  - HOLD: `in_ready`=0, `out_valid`=1, `out_vec` stable.
    - Output taken: go to FILL.
- `in_ready` and `out_valid` are decoded from state only. There is no combinational path from `out_ready` to `in_ready`, and no bypass.
- `out_vec` is never cleared between frames. Words of a discarded partial frame keep their stale data until they are overwritten.
- No arithmetic on element values: `in_data` is written bit-exact.

## Timing
- Reset values: state FILL, idx 0, `out_vec` all 0, `out_valid` 0, `frame_err` 0, `in_ready` 1.
- Latency: `out_valid` rises the cycle after the accept of element N-1.
- Throughput: at most one frame per N+1 cycles, i.e. N accepts plus at least one HOLD cycle.
- `out_valid`, once high, stays high with `out_vec` unchanged until the output is taken. `in_valid` or `in_data` activity during HOLD is ignored.
- The first `in_ready`=1 appears the cycle after the output is taken.
- `frame_err` is high for exactly the cycle following the offending accept.
- N=1: every accept goes straight to HOLD. `in_last`=0 on that accept gives `frame_err`.
- Reset asserted mid-frame or during HOLD: outputs immediately take their reset values and the partial frame is lost. After `rst_n` deasserts, the collector is in FILL and `in_ready`=1.

## Structure
- Shared package `fmap_pkg`:
  - `typedef enum logic {FILL, HOLD} collect_state_t`.
  - `function int flat_elems(int ch, int h, int w)`.
  - `$clog2`-based index width helper.
- `idx` width is `$clog2(N)`, with a minimum of 1.
- Single flat module; no sub-module is needed. Write enables are one-hot on idx per WIDTH slice.

## Test plan
All scenarios use CH=2, IN_H=2, IN_W=2, WIDTH=16, so N=8.

- **Basic frame.** Drive elements 0x0001..0x0008 back-to-back with `in_last` on the 8th, `out_ready`=1.
  - `out_valid` rises the cycle after the 8th accept.
  - `out_vec[15:0]`=0x0001 and `out_vec[127:112]`=0x0008.
  - `in_ready` returns high one cycle later.
- **Output backpressure.** Hold `out_ready`=0 for 5 cycles after the frame completes, while `in_valid`=1 with junk data.
  - `in_ready`=0 and `out_vec` stable throughout.
  - The next frame starts only after the output is taken.
- **Input gaps.** Toggle `in_valid` randomly at 50% with values 0xFFF8..0xFFFF (negative values).
  - `out_vec` is bit-exact in index order.
  - No `frame_err`.
- **Early last.** Assert `in_last` on element idx 3.
  - `frame_err` pulses once and there is no `out_valid`.
  - A following clean 8-element frame completes correctly.
- **Missing last.** Send 8 elements with `in_last`=0 throughout.
  - The frame completes and `frame_err` pulses once, the same cycle `out_valid` rises.
- **Reset mid-frame.** Pull `rst_n` low after 4 accepts.
  - `out_vec`=0, `out_valid`=0 and idx=0 immediately.
  - After release, a full 8-element frame completes normally.
